// File: rtl/point_multiplier_if.sv
// Handshake bundle for the GF(2^7) elliptic-curve point multiplier.
interface point_multiplier_if;
  logic [13:0] point;
  logic [6:0]  scalar;
  logic        start;
  logic [13:0] result;
  logic        done;

  modport master (output point, scalar, start, input result, done);
  modport slave  (input point, scalar, start, output result, done);
endinterface

// File: rtl/point_multiplier.sv
// Q = k*P on y^2 + xy = x^3 + A*x^2 + B over GF(2^7); affine MSB-first double-and-add, inverse = a^126.
// Define PM_CONST_TIME_EN for constant latency: done rises exactly 1506 cycles after the start-sampling edge.
module point_multiplier #(
  parameter logic [7:0] POLY    = 8'h83,
  parameter logic [6:0] CURVE_A = 7'h01,
  parameter logic [6:0] CURVE_B = 7'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  point_multiplier_if.slave bus
);

`ifdef PM_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  typedef enum logic [4:0] {
    S_IDLE, S_SCAN, S_DBL, S_ADD,
    S_INV_SQ, S_INV_MUL, S_INV_FIN,
    S_D_LAM, S_D_LSQ, S_D_X2, S_D_Y3,
    S_A_LAM, S_A_LSQ, S_A_Y3, S_A_PAD,
    S_COMMIT, S_NEXT, S_DONE
  } state_e;

  typedef enum logic [1:0] {OVR_NONE, OVR_INF, OVR_SETP, OVR_KEEP} ovr_e;

  state_e      state;
  logic [6:0]  px, py, kreg;
  logic [2:0]  idx;
  logic [6:0]  qx, qy;
  logic        qinf;
  logic [6:0]  ia, ir;
  logic [2:0]  icnt;
  logic [6:0]  lam, t0, t1;
  logic        is_dbl, from_add;
  ovr_e        ovr;
  logic [6:0]  acc;
  logic [2:0]  mcnt;
  logic [13:0] result_r;
  logic        done_r;

  logic [6:0]  ma, mb, mul_res;
  logic        is_mul, mul_last, kbit, pinf;
  logic [2:0]  msb;
  logic        disp_is_dbl;
  ovr_e        disp_ovr;
  logic [6:0]  disp_opnd;

  assign bus.result = result_r;
  assign bus.done   = done_r;

  // One MSB-first step of the bit-serial multiplier: shift, reduce, conditionally add.
  function automatic logic [6:0] gf_step(input logic [6:0] acc_in, input logic [6:0] a,
                                         input logic b);
    logic [6:0] sh;
    sh = {acc_in[5:0], 1'b0} ^ (acc_in[6] ? POLY[6:0] : 7'h00);
    return b ? (sh ^ a) : sh;
  endfunction

  assign pinf     = (px == 7'h00) && (py == 7'h00);
  assign kbit     = kreg[idx];
  assign mul_last = (mcnt == 3'd6);
  assign is_mul   = state inside {S_INV_SQ, S_INV_MUL, S_INV_FIN, S_D_LAM, S_D_LSQ, S_D_X2,
                                  S_D_Y3, S_A_LAM, S_A_LSQ, S_A_Y3, S_A_PAD};
  assign mul_res  = gf_step((mcnt == 3'd0) ? 7'h00 : acc, ma, mb[3'd6 - mcnt]);

  always_comb begin
    msb = 3'd0;
    for (int i = 0; i < 7; i++)
      if (kreg[i]) msb = 3'(i);
  end

  always_comb begin
    ma = 7'h00;
    mb = 7'h00;
    case (state)
      S_INV_SQ, S_INV_FIN: begin ma = ir;          mb = ir;        end
      S_INV_MUL:           begin ma = ir;          mb = ia;        end
      S_D_LAM:             begin ma = qy;          mb = ir;        end
      S_D_LSQ, S_A_LSQ,
      S_A_PAD:             begin ma = lam;         mb = lam;       end
      S_D_X2:              begin ma = qx;          mb = qx;        end
      S_D_Y3:              begin ma = lam ^ 7'h01; mb = t0;        end
      S_A_LAM:             begin ma = qy ^ py;     mb = ir;        end
      S_A_Y3:              begin ma = lam;         mb = qx ^ t0;   end
      default:             begin ma = 7'h00;       mb = 7'h00;     end
    endcase
  end

  // Classify the pending group operation; degenerate cases still get a non-zero
  // inversion operand (B is guaranteed non-zero) so a constant-time dummy run is harmless.
  always_comb begin
    disp_is_dbl = 1'b1;
    disp_ovr    = OVR_NONE;
    disp_opnd   = qx;
    if (state == S_ADD) begin
      disp_is_dbl = 1'b0;
      disp_opnd   = qx ^ px;
      if (pinf)
        disp_ovr = OVR_KEEP;
      else if (qinf)
        disp_ovr = OVR_SETP;
      else if (qx == px) begin
        if (qy == py) begin
          disp_is_dbl = 1'b1;
          disp_opnd   = qx;
          disp_ovr    = (qx == 7'h00) ? OVR_INF : OVR_NONE;
        end else
          disp_ovr = OVR_INF;
      end
    end else if (qinf || (qx == 7'h00))
      disp_ovr = OVR_INF;
    if (disp_opnd == 7'h00)
      disp_opnd = CURVE_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      px       <= '0;
      py       <= '0;
      kreg     <= '0;
      idx      <= '0;
      qx       <= '0;
      qy       <= '0;
      qinf     <= 1'b0;
      ia       <= '0;
      ir       <= '0;
      icnt     <= '0;
      lam      <= '0;
      t0       <= '0;
      t1       <= '0;
      is_dbl   <= 1'b0;
      from_add <= 1'b0;
      ovr      <= OVR_NONE;
      acc      <= '0;
      mcnt     <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
    end else begin
      if (is_mul) begin
        acc  <= mul_res;
        mcnt <= mul_last ? 3'd0 : mcnt + 3'd1;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            px     <= bus.point[6:0];
            py     <= bus.point[13:7];
            kreg   <= bus.scalar;
            done_r <= 1'b0;
            state  <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (CONST_TIME) begin
            qinf  <= 1'b1;
            idx   <= 3'd6;
            state <= S_DBL;
          end else if ((kreg == 7'h00) || pinf) begin
            result_r <= 14'h0000;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end else begin
            qx   <= px;
            qy   <= py;
            qinf <= 1'b0;
            if (msb == 3'd0) begin
              result_r <= {py, px};
              done_r   <= 1'b1;
              state    <= S_DONE;
            end else begin
              idx   <= msb - 3'd1;
              state <= S_DBL;
            end
          end
        end

        S_DBL, S_ADD: begin
          is_dbl   <= disp_is_dbl;
          ovr      <= disp_ovr;
          ia       <= disp_opnd;
          ir       <= disp_opnd;
          icnt     <= 3'd0;
          from_add <= (state == S_ADD);
          if (!CONST_TIME && (disp_ovr != OVR_NONE))
            state <= S_COMMIT;
          else
            state <= S_INV_SQ;
        end

        S_INV_SQ: if (mul_last) begin
          ir    <= mul_res;
          state <= S_INV_MUL;
        end

        // Five rounds of r = r^2 * a reach a^63; the final squaring gives a^126 = a^-1.
        S_INV_MUL: if (mul_last) begin
          ir    <= mul_res;
          icnt  <= icnt + 3'd1;
          state <= (icnt == 3'd4) ? S_INV_FIN : S_INV_SQ;
        end

        S_INV_FIN: if (mul_last) begin
          ir    <= mul_res;
          state <= is_dbl ? S_D_LAM : S_A_LAM;
        end

        S_D_LAM: if (mul_last) begin
          lam   <= qx ^ mul_res;
          state <= S_D_LSQ;
        end

        S_D_LSQ: if (mul_last) begin
          t0    <= mul_res ^ lam ^ CURVE_A;
          state <= S_D_X2;
        end

        S_D_X2: if (mul_last) begin
          t1    <= mul_res;
          state <= S_D_Y3;
        end

        S_D_Y3: if (mul_last) begin
          t1    <= t1 ^ mul_res;
          state <= S_COMMIT;
        end

        S_A_LAM: if (mul_last) begin
          lam   <= mul_res;
          state <= S_A_LSQ;
        end

        S_A_LSQ: if (mul_last) begin
          t0    <= mul_res ^ lam ^ qx ^ px ^ CURVE_A;
          state <= S_A_Y3;
        end

        // The pad product only balances ADD against DBL in the constant-time build.
        S_A_Y3: if (mul_last) begin
          t1    <= mul_res ^ t0 ^ qy;
          state <= CONST_TIME ? S_A_PAD : S_COMMIT;
        end

        S_A_PAD: if (mul_last)
          state <= S_COMMIT;

        S_COMMIT: begin
          if (!(from_add && !kbit)) begin
            case (ovr)
              OVR_INF:  qinf <= 1'b1;
              OVR_SETP: begin qx <= px; qy <= py; qinf <= 1'b0; end
              OVR_KEEP: qinf <= qinf;
              default:  begin qx <= t0; qy <= t1; qinf <= 1'b0; end
            endcase
          end
          if (from_add)
            state <= S_NEXT;
          else if (CONST_TIME || kbit)
            state <= S_ADD;
          else
            state <= S_NEXT;
        end

        S_NEXT: begin
          if (idx == 3'd0) begin
            result_r <= qinf ? 14'h0000 : {qy, qx};
            done_r   <= 1'b1;
            state    <= S_DONE;
          end else begin
            idx   <= idx - 3'd1;
            state <= S_DBL;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_point_multiplier.sv
// Self-checking bench for point_multiplier: scoreboard of golden k*P values from an independent
// field/curve model (LSB-first multiply, brute-force inverse).
module tb_point_multiplier;
  localparam logic [7:0] POLY = 8'h83;
  localparam logic [6:0] CA   = 7'h01;
  localparam logic [6:0] CB   = 7'h01;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [13:0] sb_q[$];

  point_multiplier_if pm_bus();

  point_multiplier #(.POLY(POLY), .CURVE_A(CA), .CURVE_B(CB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (pm_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] gf_mul_m(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] r, aa;
    r  = 7'h00;
    aa = a;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) r ^= aa;
      aa = aa[6] ? ({aa[5:0], 1'b0} ^ POLY[6:0]) : {aa[5:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [6:0] gf_inv_m(input logic [6:0] a);
    for (int c = 1; c < 128; c++)
      if (gf_mul_m(a, 7'(c)) == 7'h01) return 7'(c);
    return 7'h00;
  endfunction

  function automatic bit on_curve(input logic [6:0] x, input logic [6:0] y);
    logic [6:0] x2;
    x2 = gf_mul_m(x, x);
    return (gf_mul_m(y, y) ^ gf_mul_m(x, y)) == (gf_mul_m(x2, x) ^ gf_mul_m(CA, x2) ^ CB);
  endfunction

  function automatic logic [13:0] pt_dbl_m(input logic [13:0] q);
    logic [6:0] x, y, lam, x3, y3;
    x = q[6:0];
    y = q[13:7];
    if (x == 7'h00) return 14'h0000;
    lam = x ^ gf_mul_m(y, gf_inv_m(x));
    x3  = gf_mul_m(lam, lam) ^ lam ^ CA;
    y3  = gf_mul_m(x, x) ^ gf_mul_m(lam ^ 7'h01, x3);
    return {y3, x3};
  endfunction

  function automatic logic [13:0] pt_add_m(input logic [13:0] q, input logic [13:0] p);
    logic [6:0] x1, y1, x2, y2, lam, x3, y3;
    if (q == 14'h0000) return p;
    if (p == 14'h0000) return q;
    x1 = q[6:0]; y1 = q[13:7];
    x2 = p[6:0]; y2 = p[13:7];
    if (x1 == x2) return (y1 == y2) ? pt_dbl_m(q) : 14'h0000;
    lam = gf_mul_m(y1 ^ y2, gf_inv_m(x1 ^ x2));
    x3  = gf_mul_m(lam, lam) ^ lam ^ x1 ^ x2 ^ CA;
    y3  = gf_mul_m(lam, x1 ^ x3) ^ x3 ^ y1;
    return {y3, x3};
  endfunction

  function automatic logic [13:0] model_mul(input logic [13:0] p, input logic [6:0] k);
    logic [13:0] q;
    q = 14'h0000;
    for (int i = 6; i >= 0; i--) begin
      q = pt_dbl_m(q);
      if (k[i]) q = pt_add_m(q, p);
    end
    return q;
  endfunction

  task automatic apply_stimulus(input logic [13:0] pt, input logic [6:0] k);
    sb_q.push_back(model_mul(pt, k));
    @(negedge clk);
    pm_bus.point  = pt;
    pm_bus.scalar = k;
    pm_bus.start  = 1'b1;
    @(negedge clk);
    pm_bus.start  = 1'b0;
    pm_bus.point  = 14'($urandom);
    pm_bus.scalar = 7'($urandom);
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    ok     = 1'b0;
    cycles = 1;
    while (cycles <= 3000) begin
      if (pm_bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pm_bus.point = 14'h3BC1; pm_bus.scalar = 7'h7F; pm_bus.start = 1'b0;
    repeat (2) @(negedge clk);
    pm_bus.start = 1'b1;
    repeat (3) @(negedge clk);
    pm_bus.start = 1'b0;
    checks++;
    if (pm_bus.result !== 14'h0000) begin
      errors++; $display("[TB] FAIL reset_result: got %h, want 0000", pm_bus.result);
    end
    checks++;
    if (pm_bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done: got %b, want 0", pm_bus.done);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (pm_bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle_done: got %b, want 0", pm_bus.done);
    end
  endtask

  task automatic test_vectors();
    logic [13:0] pts [7] = '{14'h3BC1, 14'h3BC1, 14'h0000, 14'h3BC1, 14'h3BC1, 14'h35F1, 14'h35F1};
    logic [6:0]  ks  [7] = '{7'h01, 7'h00, 7'h48, 7'h48, 7'h07, 7'h07, 7'h48};
    logic [13:0] exp;
    int cyc;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(pts[i], ks[i]);
      wait_done(cyc, ok);
      exp = sb_q.pop_front();
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL vec%0d_timeout: done low after %0d cycles, want <= 3000", i, cyc);
      end
      checks++;
      if (pm_bus.result !== exp) begin
        errors++; $display("[TB] FAIL vec%0d_result: P=%h k=%h got %h, want %h", i, pts[i], ks[i], pm_bus.result, exp);
      end
    end
    checks++;
    if (exp !== model_mul(14'h35F1, 7'h48) || pm_bus.result !== exp) begin
      errors++; $display("[TB] FAIL vec_last_hold: got %h, want %h", pm_bus.result, exp);
    end
  endtask

  task automatic test_fixed_answers();
    int cyc;
    bit ok;
    logic [13:0] exp;
    apply_stimulus(14'h3BC1, 7'h01);
    wait_done(cyc, ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || pm_bus.result !== 14'h3BC1) begin
      errors++; $display("[TB] FAIL k1_identity: got %h, want 3bc1", pm_bus.result);
    end
    apply_stimulus(14'h3BC1, 7'h00);
    wait_done(cyc, ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || pm_bus.result !== 14'h0000) begin
      errors++; $display("[TB] FAIL k0_infinity: got %h, want 0000", pm_bus.result);
    end
  endtask

  task automatic test_edges();
    logic [13:0] pt, q, exp;
    logic [6:0]  y0;
    int n, cyc;
    bit ok, found;
    y0 = 7'h00;
    for (int y = 0; y < 128; y++)
      if (gf_mul_m(7'(y), 7'(y)) == CB) y0 = 7'(y);
    apply_stimulus({y0, 7'h00}, 7'h02);
    wait_done(cyc, ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || pm_bus.result !== exp || pm_bus.result !== 14'h0000) begin
      errors++; $display("[TB] FAIL x0_double: got %h, want 0000 (model %h)", pm_bus.result, exp);
    end

    found = 1'b0;
    pt    = 14'h0000;
    n     = 0;
    for (int x = 1; x < 128 && !found; x++)
      for (int y = 0; y < 128 && !found; y++)
        if (on_curve(7'(x), 7'(y))) begin
          pt = {7'(y), 7'(x)};
          q  = pt;
          n  = 1;
          while (q != 14'h0000 && n < 128) begin
            q = pt_add_m(q, pt);
            n++;
          end
          if (q == 14'h0000 && n >= 3 && n <= 127) found = 1'b1;
        end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL order_search: got none, want a point of order 3..127");
    end else begin
      apply_stimulus(pt, 7'(n));
      wait_done(cyc, ok);
      exp = sb_q.pop_front();
      if (!ok || pm_bus.result !== 14'h0000 || exp !== 14'h0000) begin
        errors++; $display("[TB] FAIL order_n: P=%h n=%0d got %h, want 0000", pt, n, pm_bus.result);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp;
    int cyc;
    bit ok;
    apply_stimulus(14'h3BC1, 7'h48);
    repeat (40) @(negedge clk);
    pm_bus.point = 14'h35F1; pm_bus.scalar = 7'h7F; pm_bus.start = 1'b1;
    @(negedge clk);
    pm_bus.start = 1'b0;
    checks++;
    if (pm_bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_done: got %b, want 0", pm_bus.done);
    end
    wait_done(cyc, ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || pm_bus.result !== exp) begin
      errors++; $display("[TB] FAIL busy_ignore: got %h, want %h", pm_bus.result, exp);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (pm_bus.done !== 1'b1 || pm_bus.result !== exp) begin
      errors++; $display("[TB] FAIL done_hold: got done=%b res=%h, want 1 %h", pm_bus.done, pm_bus.result, exp);
    end
    apply_stimulus(14'h35F1, 7'h7F);
    wait_done(cyc, ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || pm_bus.result !== exp) begin
      errors++; $display("[TB] FAIL restart_from_done: got %h, want %h", pm_bus.result, exp);
    end
  endtask

  task automatic test_abort();
    logic [13:0] exp;
    int cyc;
    bit ok;
    apply_stimulus(14'h3BC1, 7'h7F);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pm_bus.done !== 1'b0 || pm_bus.result !== 14'h0000) begin
      errors++; $display("[TB] FAIL abort_reset: got done=%b res=%h, want 0 0000", pm_bus.done, pm_bus.result);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(14'h3BC1, 7'h01);
    wait_done(cyc, ok);
    exp = sb_q.pop_front();
    checks++;
    if (!ok || pm_bus.result !== exp) begin
      errors++; $display("[TB] FAIL abort_recover: got %h, want %h", pm_bus.result, exp);
    end
  endtask

  task automatic test_latency();
    logic [13:0] exp;
    int lat1, lat7f;
    bit ok1, ok7f;
    apply_stimulus(14'h35F1, 7'h01);
    wait_done(lat1, ok1);
    exp = sb_q.pop_front();
    checks++;
    if (!ok1 || pm_bus.result !== exp) begin
      errors++; $display("[TB] FAIL lat_k1_result: got %h, want %h", pm_bus.result, exp);
    end
    apply_stimulus(14'h35F1, 7'h7F);
    wait_done(lat7f, ok7f);
    exp = sb_q.pop_front();
    checks++;
    if (!ok7f || pm_bus.result !== exp) begin
      errors++; $display("[TB] FAIL lat_k7f_result: got %h, want %h", pm_bus.result, exp);
    end
    checks++;
`ifdef PM_CONST_TIME_EN
    if (lat1 != lat7f) begin
      errors++; $display("[TB] FAIL const_latency: k=01 took %0d, k=7f took %0d, want equal", lat1, lat7f);
    end
`else
    if (lat1 >= lat7f) begin
      errors++; $display("[TB] FAIL var_latency: k=01 took %0d, k=7f took %0d, want k=01 shorter", lat1, lat7f);
    end
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    pm_bus.start  = 1'b0;
    pm_bus.point  = 14'h0000;
    pm_bus.scalar = 7'h00;
    test_reset();
    test_vectors();
    test_fixed_answers();
    test_edges();
    test_back_to_back();
    test_abort();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
